// File: rtl/bn_pkg.sv
// Shared constants and FSM state type for the batch-norm statistics controller.
package bn_pkg;

    localparam int unsigned BN_IL    = 4;
    localparam int unsigned BN_FL    = 16;
    localparam int unsigned BN_W     = BN_IL + BN_FL;
    localparam int unsigned BN_LOG_N = 4;
    localparam int unsigned BN_EPS   = 0;

    localparam logic [BN_W-1:0] BN_SAT_MAX = '1;

    typedef enum logic [2:0] {
        S_ACCUM,
        S_CALC,
        S_REQ,
        S_WAIT,
        S_ACK,
        S_DRAIN,
        S_HOLD
    } bn_state_t;

endpackage

// File: rtl/bn_moment_acc.sv
// Running count, sum and sum-of-squares of signed samples over one batch.
module bn_moment_acc #(
    parameter int unsigned W     = 20,
    parameter int unsigned LOG_N = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clear,
    input  logic                            en,
    input  logic [W-1:0]                    sample,
    output logic signed [W+LOG_N-1:0]       sum,
    output logic [2*W+LOG_N-1:0]            sumsq,
    output logic                            done_at_n
);

    localparam int unsigned N     = 1 << LOG_N;
    localparam int unsigned SUM_W = W + LOG_N;
    localparam int unsigned SQ_W  = 2 * W + LOG_N;

    logic [LOG_N:0]        cnt;
    logic signed [W-1:0]   s;
    logic signed [2*W-1:0] sq;

    assign s  = signed'(sample);
    assign sq = (2*W)'(s) * (2*W)'(s);

    // High on the accepted sample that completes the batch.
    assign done_at_n = en && (cnt == (LOG_N+1)'(N - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            sum   <= '0;
            sumsq <= '0;
        end else if (clear) begin
            cnt   <= '0;
            sum   <= '0;
            sumsq <= '0;
        end else if (en) begin
            cnt   <= cnt + 1'b1;
            sum   <= sum + SUM_W'(s);
            sumsq <= sumsq + SQ_W'($unsigned(sq));
        end
    end

endmodule

// File: rtl/bn_std_ctrl.sv
// Batch-norm statistics controller: accumulates a batch, derives mean and variance,
// drives the shared sqrt unit and holds mean/std until the consumer takes them.
module bn_std_ctrl
    import bn_pkg::*;
#(
    parameter int unsigned IL    = BN_IL,
    parameter int unsigned FL    = BN_FL,
    parameter int unsigned LOG_N = BN_LOG_N,
    parameter int unsigned EPS   = BN_EPS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IL+FL-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [IL+FL-1:0]  sq_in,
    output logic              sq_input_ready,
    input  logic              sq_done,
    input  logic [IL+FL-1:0]  sq_out,
    output logic              sq_output_taken,
    output logic [IL+FL-1:0]  mean_out,
    output logic [IL+FL-1:0]  std_out,
    output logic              out_valid,
    input  logic              out_taken
);

    localparam int unsigned W     = IL + FL;
    localparam int unsigned SUM_W = W + LOG_N;
    localparam int unsigned SQ_W  = 2 * W + LOG_N;
    localparam logic [W-1:0] VAR_MAX = '1;

    bn_state_t state, state_nx;

    logic                    acc_en;
    logic                    acc_clear;
    logic                    acc_done;
    logic signed [SUM_W-1:0] acc_sum;
    logic [SQ_W-1:0]         acc_sumsq;

    logic signed [W-1:0]     mean_c;
    logic [SQ_W-1:0]         msq_c;
    logic signed [2*W-1:0]   mm_full;
    logic [2*W-1:0]          mm_c;
    logic signed [SQ_W:0]    var_s;
    logic [SQ_W:0]           var_pos;
    logic [SQ_W+1:0]         var_eps;
    logic [W-1:0]            var_c;

    // in_ready is registered, so it already implies the ACCUM state.
    assign acc_en = in_valid && in_ready;

    bn_moment_acc #(
        .W     (W),
        .LOG_N (LOG_N)
    ) u_acc (
        .clk       (clk),
        .reset     (reset),
        .clear     (acc_clear),
        .en        (acc_en),
        .sample    (in_data),
        .sum       (acc_sum),
        .sumsq     (acc_sumsq),
        .done_at_n (acc_done)
    );

    // Variance = E[x^2] - mean^2, clamped at zero, plus epsilon, saturated to W bits.
    always_comb begin
        mean_c  = W'(acc_sum >>> LOG_N);
        msq_c   = acc_sumsq >> (LOG_N + FL);
        mm_full = (2*W)'(mean_c) * (2*W)'(mean_c);
        mm_c    = $unsigned(mm_full) >> FL;
        var_s   = $signed({1'b0, msq_c}) - $signed({1'b0, SQ_W'(mm_c)});
        var_pos = var_s[SQ_W] ? '0 : $unsigned(var_s);
        var_eps = {1'b0, var_pos} + (SQ_W+2)'(EPS);
        var_c   = (var_eps > (SQ_W+2)'(VAR_MAX)) ? VAR_MAX : var_eps[W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_ACCUM;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        acc_clear       = 1'b0;
        sq_input_ready  = 1'b0;
        sq_output_taken = 1'b0;
        out_valid       = 1'b0;
        case (state)
            S_ACCUM: begin
                if (acc_done) state_nx = S_CALC;
            end
            S_CALC: begin
                state_nx = S_REQ;
            end
            S_REQ: begin
                sq_input_ready = 1'b1;
                state_nx       = S_WAIT;
            end
            S_WAIT: begin
                if (sq_done) state_nx = S_ACK;
            end
            S_ACK: begin
                sq_output_taken = 1'b1;
                state_nx        = S_DRAIN;
            end
            S_DRAIN: begin
                // A done still high here belongs to the result already captured.
                if (!sq_done) state_nx = S_HOLD;
            end
            S_HOLD: begin
                out_valid = 1'b1;
                if (out_taken) begin
                    acc_clear = 1'b1;
                    state_nx  = S_ACCUM;
                end
            end
            default: begin
                state_nx = S_ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready <= 1'b0;
            mean_out <= '0;
            sq_in    <= '0;
            std_out  <= '0;
        end else begin
            in_ready <= (state_nx == S_ACCUM);
            if (state == S_CALC) begin
                mean_out <= mean_c;
                sq_in    <= var_c;
            end
            if (state == S_WAIT && sq_done) begin
                std_out <= sq_out;
            end
        end
    end

endmodule

// File: tb/tb_bn_std_ctrl.sv
// Randomized bench for bn_std_ctrl with a transaction-level statistics model and a sqrt responder.
module tb_bn_std_ctrl;

    localparam int W = 20;

    logic         clk       = 1'b0;
    logic         reset     = 1'b0;
    logic [W-1:0] in_data   = '0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] sq_in;
    logic         sq_input_ready;
    logic         sq_done   = 1'b0;
    logic [W-1:0] sq_out    = '0;
    logic         sq_output_taken;
    logic [W-1:0] mean_out;
    logic [W-1:0] std_out;
    logic         out_valid;
    logic         out_taken = 1'b0;

    bn_std_ctrl #(
        .IL    (4),
        .FL    (16),
        .LOG_N (4),
        .EPS   (0)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .sq_in           (sq_in),
        .sq_input_ready  (sq_input_ready),
        .sq_done         (sq_done),
        .sq_out          (sq_out),
        .sq_output_taken (sq_output_taken),
        .mean_out        (mean_out),
        .std_out         (std_out),
        .out_valid       (out_valid),
        .out_taken       (out_taken)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Batch statistics straight from the sample list: floor mean, E[x^2] - mean^2.
    function automatic void batch_stats(input longint s[$], output logic [W-1:0] mean,
                                        output logic [W-1:0] vr);
        longint sum = 0, ssq = 0, mn, msq, mm, v;
        foreach (s[i]) begin
            sum += s[i];
            ssq += s[i] * s[i];
        end
        mn = sum / 16;
        if ((sum % 16) != 0 && sum < 0) mn -= 1;
        msq = ssq / 1048576;
        mm  = (mn * mn) / 65536;
        v   = msq - mm;
        if (v < 0) v = 0;
        v += 0;
        if (v > 64'hFFFFF) v = 64'hFFFFF;
        mean = mn[W-1:0];
        vr   = v[W-1:0];
    endfunction

    function automatic logic [W-1:0] isqrt_q(input logic [W-1:0] v);
        longint x = longint'(v) << 16;
        longint r = 0, t;
        for (int b = 18; b >= 0; b--) begin
            t = r | (longint'(1) << b);
            if (t * t <= x) r = t;
        end
        return r[W-1:0];
    endfunction

    // phase: 0 collect, 1 compute, 2 request, 3 await result, 4 acknowledge, 5 drain, 6 present
    int           ph     = 0;
    longint       q[$];
    bit           m_rdy  = 1'b0;
    logic [W-1:0] m_mean = '0, m_sqin = '0, m_std = '0;
    logic [W-1:0] c_mean, c_sqin;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ph = 0; q.delete(); m_rdy = 1'b0;
            m_mean = '0; m_sqin = '0; m_std = '0;
        end else begin
            case (ph)
                0: if (in_valid && m_rdy) begin
                    q.push_back(longint'(signed'(in_data)));
                    if (q.size() == 16) begin
                        batch_stats(q, c_mean, c_sqin);
                        ph = 1;
                    end
                end
                1: begin m_mean = c_mean; m_sqin = c_sqin; ph = 2; end
                2: ph = 3;
                3: if (sq_done) begin m_std = sq_out; ph = 4; end
                4: ph = 5;
                5: if (!sq_done) ph = 6;
                6: if (out_taken) begin q.delete(); ph = 0; end
                default: ph = 0;
            endcase
            m_rdy = (ph == 0);
        end
    end

    always @(negedge clk) begin
        chk("in_ready", in_ready, m_rdy);
        chk("sq_input_ready", sq_input_ready, ph == 2);
        chk("sq_output_taken", sq_output_taken, ph == 4);
        chk("out_valid", out_valid, ph == 6);
        chk("mean_out", mean_out, m_mean);
        chk("sq_in", sq_in, m_sqin);
        chk("std_out", std_out, m_std);
    end

    // ---------------- sqrt responder ----------------
    int           dly = 1, hold = 0;
    int           spur_req = 0, spur_seen = 0;
    int           rs = 0, rc = 0;
    logic [W-1:0] rv;

    always @(negedge clk or posedge reset) begin
        if (reset) begin
            rs = 0; sq_done = 1'b0; sq_out = '0;
        end else begin
            case (rs)
                0: if (sq_input_ready) begin
                    rv = sq_in; rc = dly; rs = 1;
                end else if (spur_req != spur_seen) begin
                    spur_seen = spur_req; sq_done = 1'b1; sq_out = 20'h12345; rc = 2; rs = 4;
                end
                1: if (rc <= 1) begin
                    sq_done = 1'b1; sq_out = isqrt_q(rv); rs = 2;
                end else rc--;
                2: if (sq_output_taken) begin
                    if (hold == 0) begin sq_done = 1'b0; rs = 0; end
                    else begin rc = hold; rs = 3; end
                end
                default: begin
                    rc--;
                    if (rc <= 0) begin sq_done = 1'b0; rs = 0; end
                end
            endcase
        end
    end

    int n_req = 0, n_ack = 0;
    always @(negedge clk) begin
        if (sq_input_ready) n_req++;
        if (sq_output_taken) n_ack++;
    end

    // ---------------- stimulus ----------------
    logic [W-1:0] pat [16];

    task automatic make_pat(input int kind);
        logic signed [W-1:0] r;
        for (int i = 0; i < 16; i++) begin
            case (kind)
                0: pat[i] = 20'h10000;
                1: pat[i] = (i % 2) ? 20'hE0000 : 20'h20000;
                2: pat[i] = (i % 2) ? 20'h90000 : 20'h70000;
                default: begin
                    r = W'($urandom);
                    pat[i] = r >>> $urandom_range(0, 4);
                end
            endcase
        end
    endtask

    task automatic send_batch(input bit junk_take, input bit spur);
        int idx = 0;
        logic r;
        for (int c = 0; c < 400 && idx < 16; c++) begin
            @(negedge clk);
            r = in_ready;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = in_valid ? pat[idx] : W'($urandom);
            out_taken = junk_take && (c == 3);
            if (spur && c == 2) spur_req++;
            @(posedge clk);
            if (in_valid && r) idx++;
        end
        @(negedge clk);
        in_valid = 1'b0; out_taken = 1'b0;
        chk("batch_accepted", idx, 16);
    endtask

    task automatic wait_out_valid();
        int n = 0;
        while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_timeout", out_valid, 1);
    endtask

    task automatic take_out(input int k, input bit junk_valid);
        repeat (k) begin
            @(negedge clk);
            in_valid = junk_valid; in_data = W'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0; out_taken = 1'b1;
        @(negedge clk);
        out_taken = 1'b0;
        chk("in_ready_after_take", in_ready, 1);
    endtask

    initial begin
        int r0, a0, n;
        logic [W-1:0] hm, hs;

        #1 reset = 1'b1;
        #11;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sq_input_ready", sq_input_ready, 0);
        chk("rst_mean_out", mean_out, 0);
        chk("rst_std_out", std_out, 0);
        #10 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        // 1.0 constant: zero variance
        make_pat(0); dly = 1; hold = 0;
        send_batch(1'b0, 1'b0);
        wait_out_valid();
        chk("b1_mean", mean_out, 20'h10000);
        chk("b1_sq_in", sq_in, 20'h00000);
        chk("b1_std", std_out, 20'h00000);
        take_out(2, 1'b0);

        // +-2.0 with a stray done and stray out_taken during accumulation
        make_pat(1); dly = 4; hold = 0;
        send_batch(1'b1, 1'b1);
        wait_out_valid();
        chk("b2_mean", mean_out, 20'h00000);
        chk("b2_sq_in", sq_in, 20'h40000);
        chk("b2_std", std_out, 20'h20000);
        chk("b2_model_sq_in", m_sqin, 20'h40000);
        take_out(1, 1'b0);

        // +-7.0 saturating variance, slow sqrt with lingering done
        make_pat(2); dly = 30; hold = 3;
        r0 = n_req; a0 = n_ack;
        send_batch(1'b0, 1'b0);
        wait_out_valid();
        chk("b3_sq_in", sq_in, 20'hFFFFF);
        chk("b3_mean", mean_out, 20'h00000);
        chk("b3_req_pulses", n_req - r0, 1);
        chk("b3_ack_pulses", n_ack - a0, 1);
        chk("b3_done_low_in_hold", sq_done, 0);
        take_out(0, 1'b0);

        // random batch, consumer stalls with in_valid held high
        make_pat(3); dly = 2; hold = 1;
        send_batch(1'b0, 1'b0);
        wait_out_valid();
        hm = mean_out; hs = std_out;
        repeat (10) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = W'($urandom);
        end
        chk("stall_mean_stable", mean_out, hm);
        chk("stall_std_stable", std_out, hs);
        chk("stall_out_valid", out_valid, 1);
        take_out(0, 1'b1);

        for (int b = 0; b < 5; b++) begin
            make_pat(3);
            dly = $urandom_range(1, 8); hold = $urandom_range(0, 4);
            send_batch(1'(b % 2), 1'(b == 3));
            wait_out_valid();
            take_out($urandom_range(0, 5), 1'(b % 2));
        end

        // reset while awaiting sqrt result
        make_pat(3); dly = 30; hold = 0;
        send_batch(1'b0, 1'b0);
        n = 0;
        while (!sq_input_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen_timeout", sq_input_ready, 1);
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_in_ready", in_ready, 0);
        chk("async_mean_out", mean_out, 0);
        chk("async_sq_in", sq_in, 0);
        chk("async_std_out", std_out, 0);
        chk("async_out_valid", out_valid, 0);
        chk("async_sq_output_taken", sq_output_taken, 0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        make_pat(0); dly = 1; hold = 0;
        send_batch(1'b0, 1'b0);
        wait_out_valid();
        chk("post_rst_mean", mean_out, 20'h10000);
        take_out(1, 1'b0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
